tp_serial_add_ctrl: RTL and testbench
=====================================

// Module: tp_serial_add_ctrl
// PURPOSE
// - Clocked sequencer: one dual-rail two-phase (TP) full_adder adds W-bit words bit-serially, LSB first.
// - Operand word in on valid/ready; per bit, drives a/b/c_in links and collects s/c_out links; fed-back c_out is next c_in.
// - Sits on the boundary between the synchronous host and the async fn fabric; rst is shared with the fabric.
// PARAMETERS
// - W            4   operand width in bits (>=1)
// - SYNC_STAGES  2   flop stages on every inbound async signal (>=2)
// - TIMEOUT_CYC  255 per-bit watchdog limit in clk cycles (used only with TP_ADD_TIMEOUT_EN)
// PORTS
// - clk        in   1  clock
// - rst        in   1  reset; synchronous, active-high
// - op_valid   in   1  operand word valid
// - op_ready   out  1  controller idle and able to accept an operand word
// - op_a       in   W  operand A
// - op_b       in   W  operand B
// - op_cin     in   1  carry in for bit 0
// - a_data     out  2  link a, rail[v] toggles to send bit v
// - b_data     out  2  link b
// - cin_data   out  2  link c_in
// - a_ack      in   1  link a ack, toggles per consumed token (async)
// - b_ack      in   1  link b ack (async)
// - cin_ack    in   1  link c_in ack (async)
// - s_data     in   2  link s from adder (async)
// - cout_data  in   2  link c_out from adder (async)
// - s_ack      out  1  ack toggle to s link
// - cout_ack   out  1  ack toggle to c_out link
// - res_valid  out  1  result valid
// - res_ready  in   1  result consumed
// - res_sum    out  W  sum
// - res_cout   out  1  final carry
// - err        out  1  sticky protocol/timeout error
// BEHAVIOUR
// - Reset: all data/ack outputs 0, op_ready=0 in the rst cycle then 1, res_valid=0, res_sum=0, res_cout=0, err=0, FSM=IDLE, bit index 0, all phase registers 0.
// - rst mid-operation: abandon word, no result; the fabric resets on the same rst, so all phases restart at 0.
// - Inbound signals pass SYNC_STAGES flops before any use. Events are detected against registered previous phases.
// - Token on a link: exactly one rail differs from its previous phase. Both rails differing -> ERR.
// - IDLE: op_ready=1. On op_valid&op_ready, latch op_a, op_b, and carry=op_cin, set i=0, go to ISSUE.
// - ISSUE (1 cycle): toggle a_data[op_a[i]], b_data[op_b[i]], cin_data[carry]. Go to WAIT.
// - WAIT: track 5 completion flags (a_ack, b_ack, cin_ack toggled; s, cout token). Arrival in any order or in the same cycle is legal. All 5 set -> SETTLE.
// - SETTLE (1 cycle): sum[i]=s rail, carry=cout rail; toggle s_ack and cout_ack; clear flags. If i==W-1, go to DONE; otherwise i++ and go to ISSUE.
// - DONE: res_valid=1 with res_sum/res_cout stable. On res_ready, go to IDLE. Output is held indefinitely while res_ready=0.
// - ERR: err=1. Issue nothing and ignore all links; exit only by rst.
// - Latency, op accept to res_valid: W*(2+SYNC_STAGES+fabric delay+1)+1 cycles minimum.
// - Events that arrive outside WAIT are ERR, except s/cout tokens whose ack is already toggled (none).
// CONFIGURATION
// - TP_ADD_TIMEOUT_EN defined: an 8..32-bit counter clears in ISSUE and counts in WAIT. Reaching TIMEOUT_CYC -> ERR, err=1.
// - TP_ADD_TIMEOUT_EN undefined: no counter; WAIT waits forever; err comes only from protocol violations.
// TESTING (W=4, SYNC_STAGES=2, full_adder ENC="TP" as the far end)
// - a=0x3, b=0x5, cin=0 -> res_sum=0x8, res_cout=0; exactly 4 toggles each on a_data, b_data, cin_data.
// - a=0xF, b=0x1, cin=0 -> res_sum=0x0, res_cout=1; a=0xF, b=0xF, cin=1 -> 0xF, res_cout=1.
// - Back-to-back ops, op_valid held with res_ready=1 -> both results correct in order; all links end phase-consistent.
// - res_ready=0 for 50 cycles in DONE -> res_valid/res_sum stable, op_ready=0; released -> IDLE next cycle.
// - Stub model drops s token (TP_ADD_TIMEOUT_EN, TIMEOUT_CYC=20) -> err=1 at 20 cycles in WAIT; also toggle both rails of s -> err=1.
// - rst asserted during bit 2 -> next cycle all outputs at reset values; new op 0x2+0x2 -> 0x4.

Source files
------------

// File: rtl/tp_serial_add_ctrl.sv
// Bit-serial adder sequencer driving one dual-rail two-phase full adder, LSB first.
// Optional per-bit WAIT watchdog is compiled in with `define TP_ADD_TIMEOUT_EN.
module tp_serial_add_ctrl #(
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_cin,
    output logic [1:0]   a_data,
    output logic [1:0]   b_data,
    output logic [1:0]   cin_data,
    input  logic         a_ack,
    input  logic         b_ack,
    input  logic         cin_ack,
    input  logic [1:0]   s_data,
    input  logic [1:0]   cout_data,
    output logic         s_ack,
    output logic         cout_ack,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_sum,
    output logic         res_cout,
    output logic         err
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam int NI = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SETTLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic [1:0]    a_data_q, a_data_d;
    logic [1:0]    b_data_q, b_data_d;
    logic [1:0]    cin_data_q, cin_data_d;
    logic          s_ack_q, s_ack_d;
    logic          cout_ack_q, cout_ack_d;
    logic [4:0]    flags_q, flags_d;
    logic          s_rail_q, s_rail_d;
    logic          cout_rail_q, cout_rail_d;

    // Inbound bit map: [0] a_ack, [1] b_ack, [2] cin_ack, [4:3] s_data, [6:5] cout_data
    logic [NI-1:0] async_in;
    logic [NI-1:0] sync_q [SYNC_STAGES];
    logic [NI-1:0] sync_d [SYNC_STAGES];
    logic [NI-1:0] prev_q, prev_d;
    logic [NI-1:0] in_s;
    logic [NI-1:0] diff;

    assign async_in = {cout_data, s_data, cin_ack, b_ack, a_ack};

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = async_in;
            end else begin : g_rest
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    assign in_s   = sync_q[SYNC_STAGES-1];
    assign prev_d = in_s;
    assign diff   = in_s ^ prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            prev_q <= prev_d;
        end
    end

    logic       a_ev, b_ev, cin_ev, any_ev;
    logic [1:0] s_diff, cout_diff;
    logic       s_tok, s_bad, cout_tok, cout_bad;
    logic       dup_ev;

    assign a_ev      = diff[0];
    assign b_ev      = diff[1];
    assign cin_ev    = diff[2];
    assign s_diff    = diff[4:3];
    assign cout_diff = diff[6:5];
    assign s_tok     = ^s_diff;
    assign s_bad     = &s_diff;
    assign cout_tok  = ^cout_diff;
    assign cout_bad  = &cout_diff;
    assign any_ev    = |diff;
    // A second event on a link whose completion is already recorded is a protocol break.
    assign dup_ev    = |(flags_q & {cout_tok, s_tok, cin_ev, b_ev, a_ev});

    logic to_hit;

`ifdef TP_ADD_TIMEOUT_EN
    localparam int TW_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 32) ? 32 : TW_RAW);

    logic [TW-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == S_ISSUE) begin
            to_cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    assign to_hit = (state_q == S_WAIT) && (to_cnt_d == TW'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        a_data_d    = a_data_q;
        b_data_d    = b_data_q;
        cin_data_d  = cin_data_q;
        s_ack_d     = s_ack_q;
        cout_ack_d  = cout_ack_q;
        flags_d     = flags_q;
        s_rail_d    = s_rail_q;
        cout_rail_d = cout_rail_q;

        case (state_q)
            S_IDLE: begin
                if (any_ev) begin
                    state_d = S_ERR;
                end else if (op_valid) begin
                    opa_d   = op_a;
                    opb_d   = op_b;
                    carry_d = op_cin;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (any_ev) begin
                    state_d = S_ERR;
                end else begin
                    a_data_d[opa_q[idx_q]] = ~a_data_q[opa_q[idx_q]];
                    b_data_d[opb_q[idx_q]] = ~b_data_q[opb_q[idx_q]];
                    cin_data_d[carry_q]    = ~cin_data_q[carry_q];
                    flags_d                = '0;
                    state_d                = S_WAIT;
                end
            end
            S_WAIT: begin
                if (s_bad || cout_bad || dup_ev) begin
                    state_d = S_ERR;
                end else begin
                    flags_d = flags_q | {cout_tok, s_tok, cin_ev, b_ev, a_ev};
                    if (s_tok) begin
                        s_rail_d = s_diff[1];
                    end
                    if (cout_tok) begin
                        cout_rail_d = cout_diff[1];
                    end
                    if (&flags_d) begin
                        state_d = S_SETTLE;
                    end else if (to_hit) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_SETTLE: begin
                if (any_ev) begin
                    state_d = S_ERR;
                end else begin
                    sum_d[idx_q] = s_rail_q;
                    carry_d      = cout_rail_q;
                    s_ack_d      = ~s_ack_q;
                    cout_ack_d   = ~cout_ack_q;
                    flags_d      = '0;
                    if (idx_q == IW'(W - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                if (any_ev) begin
                    state_d = S_ERR;
                end else if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            a_data_q    <= '0;
            b_data_q    <= '0;
            cin_data_q  <= '0;
            s_ack_q     <= 1'b0;
            cout_ack_q  <= 1'b0;
            flags_q     <= '0;
            s_rail_q    <= 1'b0;
            cout_rail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            a_data_q    <= a_data_d;
            b_data_q    <= b_data_d;
            cin_data_q  <= cin_data_d;
            s_ack_q     <= s_ack_d;
            cout_ack_q  <= cout_ack_d;
            flags_q     <= flags_d;
            s_rail_q    <= s_rail_d;
            cout_rail_q <= cout_rail_d;
        end
    end

    // op_ready is gated by rst so the host never sees it high during the reset cycle.
    assign op_ready  = (state_q == S_IDLE) && !rst;
    assign res_valid = (state_q == S_DONE);
    assign res_sum   = sum_q;
    assign res_cout  = carry_q;
    assign err       = (state_q == S_ERR);
    assign a_data    = a_data_q;
    assign b_data    = b_data_q;
    assign cin_data  = cin_data_q;
    assign s_ack     = s_ack_q;
    assign cout_ack  = cout_ack_q;

endmodule

// File: tb/tb_tp_serial_add_ctrl.sv
// Directed bench for tp_serial_add_ctrl with a behavioural TP full-adder as the far end.
`timescale 1ns/1ps
module tb_tp_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_a, op_b;
    logic       op_cin;
    logic [1:0] a_data, b_data, cin_data;
    logic       a_ack, b_ack, cin_ack;
    logic [1:0] s_data, cout_data;
    logic       s_ack, cout_ack;
    logic       res_valid, res_ready;
    logic [3:0] res_sum;
    logic       res_cout;
    logic       err;

    int checks = 0;
    int errors = 0;
    int fab_mode = 0;     // 0 normal, 1 drop s token, 2 toggle both s rails
    int a_tok_cnt = 0;

    always #5 clk = ~clk;

    tp_serial_add_ctrl #(
        .W(4),
        .SYNC_STAGES(2),
        .TIMEOUT_CYC(20)
    ) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .a_data(a_data), .b_data(b_data), .cin_data(cin_data),
        .a_ack(a_ack), .b_ack(b_ack), .cin_ack(cin_ack),
        .s_data(s_data), .cout_data(cout_data),
        .s_ack(s_ack), .cout_ack(cout_ack),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout),
        .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s value=0x%0h", tag, obs);
        end
    endtask

    // Far-end full adder: collects a/b/c_in tokens, acks them, emits s/c_out, waits for their acks.
    initial begin
        logic [1:0] pa, pb, pc, d;
        logic       ba, bb, bc, ga, gb, gc, pend, psa, pca, s, co;
        a_ack = 0; b_ack = 0; cin_ack = 0; s_data = 0; cout_data = 0;
        pa = 0; pb = 0; pc = 0; ba = 0; bb = 0; bc = 0;
        ga = 0; gb = 0; gc = 0; pend = 0; psa = 0; pca = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                a_ack = 0; b_ack = 0; cin_ack = 0; s_data = 0; cout_data = 0;
                pa = 0; pb = 0; pc = 0; ga = 0; gb = 0; gc = 0;
                pend = 0; psa = 0; pca = 0;
            end else begin
                if (a_data != pa) begin d = a_data ^ pa; ba = d[1]; pa = a_data; ga = 1; a_tok_cnt++; end
                if (b_data != pb) begin d = b_data ^ pb; bb = d[1]; pb = b_data; gb = 1; end
                if (cin_data != pc) begin d = cin_data ^ pc; bc = d[1]; pc = cin_data; gc = 1; end
                if (pend && (s_ack != psa) && (cout_ack != pca)) begin
                    pend = 0; psa = s_ack; pca = cout_ack;
                end
                if (ga && gb && gc && !pend) begin
                    s  = ba ^ bb ^ bc;
                    co = (ba & bb) | (ba & bc) | (bb & bc);
                    a_ack = ~a_ack; b_ack = ~b_ack; cin_ack = ~cin_ack;
                    if (fab_mode == 2) s_data = ~s_data;
                    else if (fab_mode != 1) s_data[s] = ~s_data[s];
                    cout_data[co] = ~cout_data[co];
                    pend = 1; ga = 0; gb = 0; gc = 0;
                end
            end
        end
    end

    task automatic wait_accept(input string tag);
        int n = 0;
        while (!op_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) check({tag, "_accept_timeout"}, 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (!res_valid && n < 500) begin @(posedge clk); #1; n++; end
        check({tag, "_valid"}, res_valid, 1);
    endtask

    task automatic check_phases(input string tag);
        check({tag, "_phase"}, {^a_data, ^b_data, ^cin_data, ^s_data, ^cout_data},
              {a_ack, b_ack, cin_ack, s_ack, cout_ack});
    endtask

    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic ci, input logic [3:0] es, input logic ec);
        int tok0;
        tok0 = a_tok_cnt;
        op_a = a; op_b = b; op_cin = ci; op_valid = 1; res_ready = 1;
        wait_accept(tag);
        op_valid = 0;
        wait_result(tag);
        check({tag, "_sum"}, res_sum, es);
        check({tag, "_cout"}, res_cout, ec);
        check({tag, "_a_tokens"}, a_tok_cnt - tok0, 4);
        @(posedge clk); #1;
        check({tag, "_idle"}, op_ready, 1);
        check_phases(tag);
    endtask

    task automatic pulse_rst();
        op_valid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        int n, tok0;
        logic stable;
        rst = 1; op_valid = 0; op_a = 0; op_b = 0; op_cin = 0; res_ready = 1;
        @(posedge clk); #1;
        check("rst_op_ready", op_ready, 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        check("rst_outputs", {a_data, b_data, cin_data, s_ack, cout_ack, res_valid, res_sum, res_cout, err}, 0);
        check("rst_ready_after", op_ready, 1);

        run_op("add_3_5", 4'h3, 4'h5, 1'b0, 4'h8, 1'b0);
        run_op("add_f_1", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
        run_op("add_f_f_c", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1);

        // back-to-back with op_valid held
        op_a = 4'h6; op_b = 4'h7; op_cin = 0; op_valid = 1; res_ready = 1;
        wait_accept("b2b1");
        op_a = 4'h9; op_b = 4'h8; op_cin = 1;
        wait_result("b2b1");
        check("b2b1_sum", {res_cout, res_sum}, 5'h0D);
        wait_accept("b2b2");
        op_valid = 0;
        wait_result("b2b2");
        check("b2b2_sum", {res_cout, res_sum}, 5'h12);
        @(posedge clk); #1;
        check_phases("b2b2");

        // result stall
        res_ready = 0; op_a = 4'hA; op_b = 4'h5; op_cin = 0; op_valid = 1;
        wait_accept("stall");
        op_valid = 0;
        wait_result("stall");
        stable = 1;
        repeat (50) begin
            @(posedge clk); #1;
            if (!res_valid || res_sum !== 4'hF || res_cout !== 1'b0 || op_ready) stable = 0;
        end
        check("stall_stable", stable, 1);
        res_ready = 1;
        @(posedge clk); #1;
        check("stall_release", {op_ready, res_valid}, 2'b10);

        // reset during bit 2
        tok0 = a_tok_cnt;
        op_a = 4'hF; op_b = 4'h1; op_cin = 0; op_valid = 1;
        wait_accept("midrst");
        op_valid = 0;
        n = 0;
        while ((a_tok_cnt - tok0) < 3 && n < 200) begin @(posedge clk); #1; n++; end
        check("midrst_bit2_reached", a_tok_cnt - tok0, 3);
        rst = 1;
        @(posedge clk); #1;
        check("midrst_outputs", {a_data, b_data, cin_data, s_ack, cout_ack, res_valid, res_sum, res_cout, err, op_ready}, 0);
        rst = 0;
        @(posedge clk); #1;
        run_op("after_rst_2_2", 4'h2, 4'h2, 1'b0, 4'h4, 1'b0);

        // both rails of s toggled
        fab_mode = 2;
        op_a = 4'h1; op_b = 4'h1; op_cin = 0; op_valid = 1;
        wait_accept("dbl_s");
        op_valid = 0;
        n = 0;
        while (!err && n < 100) begin @(posedge clk); #1; n++; end
        check("dbl_s_err", err, 1);
        repeat (5) @(posedge clk);
        #1;
        check("dbl_s_sticky", {err, res_valid, op_ready}, 3'b100);
        fab_mode = 0;
        pulse_rst();
        check("dbl_s_cleared", {err, op_ready}, 2'b01);

        // dropped s token
        fab_mode = 1;
        op_a = 4'h1; op_b = 4'h0; op_cin = 0; op_valid = 1;
        wait_accept("drop_s");
        op_valid = 0;
`ifdef TP_ADD_TIMEOUT_EN
        repeat (20) @(posedge clk);
        #1;
        check("drop_s_pre_timeout", err, 0);
        @(posedge clk); #1;
        check("drop_s_timeout", err, 1);
`else
        repeat (100) @(posedge clk);
        #1;
        check("drop_s_waits", {err, res_valid}, 2'b00);
`endif
        fab_mode = 0;
        pulse_rst();
        run_op("final_3_5", 4'h3, 4'h5, 1'b0, 4'h8, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
